// File: rtl/rv_regfile_pkg.sv
// Shared constants and types for the register-bank write-back scheduler.
package rv_regfile_pkg;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam logic [AW-1:0] REG_ZERO = 5'd0;

   typedef logic [AW-1:0] reg_addr_t;

   typedef struct packed {
      logic            valid;
      reg_addr_t       rd;
      logic [XLEN-1:0] data;
   } wb_req_t;
endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin write-back arbiter (ALU = requester 0, LSU = requester 1).
// Priority flips only when both requesters compete in the same cycle.
module wb_rr_arbiter
   import rv_regfile_pkg::*;
#(
   parameter int AW_P   = AW,
   parameter int XLEN_P = XLEN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_alu_valid,
   input  logic [AW_P-1:0]   i_alu_rd,
   input  logic [XLEN_P-1:0] i_alu_data,
   input  logic              i_lsu_valid,
   input  logic [AW_P-1:0]   i_lsu_rd,
   input  logic [XLEN_P-1:0] i_lsu_data,
   output logic [1:0]        o_gnt,
   output logic              o_sel_valid,
   output logic [AW_P-1:0]   o_sel_rd,
   output logic [XLEN_P-1:0] o_sel_data
);
   logic r_prio;
   logic w_both;

   assign w_both   = i_alu_valid && i_lsu_valid;
   assign o_gnt[0] = i_alu_valid && (!i_lsu_valid || !r_prio);
   assign o_gnt[1] = i_lsu_valid && (!i_alu_valid ||  r_prio);

   assign o_sel_valid = |o_gnt;
   assign o_sel_rd    = o_gnt[0] ? i_alu_rd   : i_lsu_rd;
   assign o_sel_data  = o_gnt[0] ? i_alu_data : i_lsu_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prio <= 1'b0;
      end else if (w_both) begin
         r_prio <= ~r_prio;
      end
   end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-port sequencer for the 32x32 register bank: arbitration, pending-write
// scoreboard and decode stall. Optional forwarding enabled by REGFILE_BYPASS_EN.
module regfile_wb_scheduler
   import rv_regfile_pkg::*;
#(
   parameter int XLEN_P = XLEN,
   parameter int NREG_P = NREG,
   parameter int AW_P   = AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   input  logic              issue_has_rd,
   input  logic [AW_P-1:0]   issue_rd,
   input  logic [AW_P-1:0]   rs1_addr,
   input  logic [AW_P-1:0]   rs2_addr,
   output logic              issue_stall,
   input  logic              alu_valid,
   input  logic [AW_P-1:0]   alu_rd,
   input  logic [XLEN_P-1:0] alu_data,
   output logic              alu_ready,
   input  logic              lsu_valid,
   input  logic [AW_P-1:0]   lsu_rd,
   input  logic [XLEN_P-1:0] lsu_data,
   output logic              lsu_ready,
   output logic              rf_we,
   output logic [AW_P-1:0]   rf_waddr,
   output logic [XLEN_P-1:0] rf_wdata,
   output logic              byp1_valid,
   output logic              byp2_valid,
   output logic [XLEN_P-1:0] byp_data
);
   logic [NREG_P-1:0] r_pend;
   logic              r_we;
   logic [AW_P-1:0]   r_waddr;
   logic [XLEN_P-1:0] r_wdata;

   logic [1:0]        w_gnt;
   logic              w_sel_valid;
   logic [AW_P-1:0]   w_sel_rd;
   logic [XLEN_P-1:0] w_sel_data;
   logic              w_byp1;
   logic              w_byp2;
   logic              w_hz1;
   logic              w_hz2;
   logic              w_hzd;
   logic              w_set;
   logic [NREG_P-1:0] w_pend_nxt;

   wb_rr_arbiter #(.AW_P(AW_P), .XLEN_P(XLEN_P)) u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_alu_valid (alu_valid),
      .i_alu_rd    (alu_rd),
      .i_alu_data  (alu_data),
      .i_lsu_valid (lsu_valid),
      .i_lsu_rd    (lsu_rd),
      .i_lsu_data  (lsu_data),
      .o_gnt       (w_gnt),
      .o_sel_valid (w_sel_valid),
      .o_sel_rd    (w_sel_rd),
      .o_sel_data  (w_sel_data)
   );

   assign alu_ready = w_gnt[0];
   assign lsu_ready = w_gnt[1];

`ifdef REGFILE_BYPASS_EN
   assign w_byp1   = r_we && (rs1_addr == r_waddr) && (rs1_addr != REG_ZERO);
   assign w_byp2   = r_we && (rs2_addr == r_waddr) && (rs2_addr != REG_ZERO);
   assign byp_data = r_wdata;
`else
   assign w_byp1   = 1'b0;
   assign w_byp2   = 1'b0;
   assign byp_data = '0;
`endif
   assign byp1_valid = w_byp1;
   assign byp2_valid = w_byp2;

   // Destination hazard is never masked by forwarding: the older write must retire first.
   assign w_hz1 = (rs1_addr != REG_ZERO) && r_pend[rs1_addr] && !w_byp1;
   assign w_hz2 = (rs2_addr != REG_ZERO) && r_pend[rs2_addr] && !w_byp2;
   assign w_hzd = issue_has_rd && (issue_rd != REG_ZERO) && r_pend[issue_rd];
   assign issue_stall = issue_valid && (w_hz1 || w_hz2 || w_hzd);

   assign w_set = issue_valid && issue_has_rd && !issue_stall && (issue_rd != REG_ZERO);

   always_comb begin
      w_pend_nxt = r_pend;
      if (r_we) w_pend_nxt[r_waddr] = 1'b0;
      if (w_set) w_pend_nxt[issue_rd] = 1'b1;
      w_pend_nxt[0] = 1'b0;
   end

   // Writes to x0 complete the handshake but never reach the bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend  <= '0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         r_we   <= w_sel_valid && (w_sel_rd != REG_ZERO);
         if (w_sel_valid && (w_sel_rd != REG_ZERO)) begin
            r_waddr <= w_sel_rd;
            r_wdata <= w_sel_data;
         end
      end
   end

   assign rf_we    = r_we;
   assign rf_waddr = r_waddr;
   assign rf_wdata = r_wdata;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: directed vectors, expected writes queued
// at grant time and retired by a monitor watching rf_we.
module tb_regfile_wb_scheduler;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid, issue_has_rd;
   logic [4:0]  issue_rd, rs1_addr, rs2_addr;
   logic        issue_stall;
   logic        alu_valid, lsu_valid;
   logic [4:0]  alu_rd, lsu_rd;
   logic [31:0] alu_data, lsu_data;
   logic        alu_ready, lsu_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        byp1_valid, byp2_valid;
   logic [31:0] byp_data;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   wb_t exp_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   regfile_wb_scheduler dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue_valid  (issue_valid),
      .issue_has_rd (issue_has_rd),
      .issue_rd     (issue_rd),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .issue_stall  (issue_stall),
      .alu_valid    (alu_valid),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .alu_ready    (alu_ready),
      .lsu_valid    (lsu_valid),
      .lsu_rd       (lsu_rd),
      .lsu_data     (lsu_data),
      .lsu_ready    (lsu_ready),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .byp1_valid   (byp1_valid),
      .byp2_valid   (byp2_valid),
      .byp_data     (byp_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [4:0] rd, input logic [31:0] data);
      wb_t e;
      e.rd   = rd;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Monitor: every bank write must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rf_we) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got x%0d=%h expected no write", rf_waddr, rf_wdata);
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            chk("wb_addr", {27'd0, rf_waddr}, {27'd0, e.rd});
            chk("wb_data", rf_wdata, e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      issue_valid = 0; issue_has_rd = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_we",    {31'd0, rf_we}, 32'd0);
      chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      chk("rst_ready", {30'd0, alu_ready, lsu_ready}, 32'd0);
      chk("rst_byp",   {30'd0, byp1_valid, byp2_valid}, 32'd0);
      chk("rst_bdata", byp_data, 32'd0);
      cyc();
      rst_n = 1'b1;

      // Single ALU write-back
      cyc();
      alu_valid = 1; alu_rd = 5'd1; alu_data = 32'hDEADBEEF; push(5'd1, 32'hDEADBEEF);
      @(negedge clk);
      chk("alu_only_ready", {30'd0, alu_ready, lsu_ready}, 32'h2);
      cyc();
      alu_valid = 0;
      @(negedge clk);
      chk("alu_idle_ready", {31'd0, alu_ready}, 32'd0);

      // Round-robin contention
      cyc();
      alu_valid = 1; alu_rd = 5'd2; alu_data = 32'hBADC0DE0;
      lsu_valid = 1; lsu_rd = 5'd3; lsu_data = 32'h12345678; push(5'd2, 32'hBADC0DE0);
      @(negedge clk);
      chk("rr0_ready", {30'd0, alu_ready, lsu_ready}, 32'h2);
      cyc();
      alu_rd = 5'd6; alu_data = 32'h00000066; push(5'd3, 32'h12345678);
      @(negedge clk);
      chk("rr1_ready", {30'd0, alu_ready, lsu_ready}, 32'h1);
      cyc();
      lsu_valid = 0; push(5'd6, 32'h00000066);
      @(negedge clk);
      chk("rr2_ready", {30'd0, alu_ready, lsu_ready}, 32'h2);
      cyc();
      alu_rd = 5'd8; alu_data = 32'h00000088;
      lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 32'h00000099; push(5'd8, 32'h00000088);
      @(negedge clk);
      chk("rr3_prio_alu", {30'd0, alu_ready, lsu_ready}, 32'h2);
      cyc();
      alu_valid = 0; push(5'd9, 32'h00000099);
      @(negedge clk);
      chk("rr4_ready", {30'd0, alu_ready, lsu_ready}, 32'h1);
      cyc();
      lsu_valid = 0;

      // RAW hazard on x5
      cyc();
      issue_valid = 1; issue_has_rd = 1; issue_rd = 5'd5; rs1_addr = 0; rs2_addr = 0;
      @(negedge clk);
      chk("raw_issue", {31'd0, issue_stall}, 32'd0);
      cyc();
      issue_has_rd = 0; rs1_addr = 5'd5;
      @(negedge clk);
      chk("raw_stall0", {31'd0, issue_stall}, 32'd1);
      cyc();
      @(negedge clk);
      chk("raw_stall1", {31'd0, issue_stall}, 32'd1);
      cyc();
      alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h00000055; push(5'd5, 32'h00000055);
      @(negedge clk);
      chk("raw_stall_gnt", {31'd0, issue_stall}, 32'd1);
      cyc();
      alu_valid = 0;
      @(negedge clk);
      chk("raw_stall_we", {31'd0, issue_stall}, BYP ? 32'd0 : 32'd1);
      chk("raw_byp1", {31'd0, byp1_valid}, BYP ? 32'd1 : 32'd0);
      chk("raw_bdata", byp_data, BYP ? 32'h00000055 : 32'd0);
      cyc();
      @(negedge clk);
      chk("raw_release", {31'd0, issue_stall}, 32'd0);
      cyc();
      issue_valid = 0; rs1_addr = 0;

      // Zero sources and write to x0 while x10 pending
      cyc();
      issue_valid = 1; issue_has_rd = 1; issue_rd = 5'd10;
      @(negedge clk);
      chk("x10_issue", {31'd0, issue_stall}, 32'd0);
      cyc();
      issue_has_rd = 0; rs1_addr = 0; rs2_addr = 0;
      @(negedge clk);
      chk("zero_src", {31'd0, issue_stall}, 32'd0);
      cyc();
      rs2_addr = 5'd10;
      lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'hFFFFFFFF;
      @(negedge clk);
      chk("x10_stall", {31'd0, issue_stall}, 32'd1);
      chk("x0_lsu_ready", {31'd0, lsu_ready}, 32'd1);
      cyc();
      lsu_valid = 0;
      @(negedge clk);
      chk("x0_no_we", {31'd0, rf_we}, 32'd0);
      chk("x0_pend_kept", {31'd0, issue_stall}, 32'd1);
      cyc();
      issue_valid = 0; rs2_addr = 0;
      alu_valid = 1; alu_rd = 5'd10; alu_data = 32'h000000A0; push(5'd10, 32'h000000A0);
      cyc();
      alu_valid = 0;

      // WAW hazard on x7
      cyc();
      issue_valid = 1; issue_has_rd = 1; issue_rd = 5'd7;
      @(negedge clk);
      chk("waw_first", {31'd0, issue_stall}, 32'd0);
      cyc();
      @(negedge clk);
      chk("waw_second", {31'd0, issue_stall}, 32'd1);
      cyc();
      alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h00000077; push(5'd7, 32'h00000077);
      @(negedge clk);
      chk("waw_gnt", {31'd0, issue_stall}, 32'd1);
      cyc();
      alu_valid = 0;
      @(negedge clk);
      chk("waw_we", {31'd0, issue_stall}, 32'd1);
      cyc();
      @(negedge clk);
      chk("waw_release", {31'd0, issue_stall}, 32'd0);
      cyc();
      issue_valid = 0;
      alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h00000707; push(5'd7, 32'h00000707);
      cyc();
      alu_valid = 0;

      // Forwarding on rs2 = x4
      cyc();
      issue_valid = 1; issue_has_rd = 1; issue_rd = 5'd4; rs1_addr = 0; rs2_addr = 0;
      @(negedge clk);
      chk("x4_issue", {31'd0, issue_stall}, 32'd0);
      cyc();
      issue_has_rd = 0; rs2_addr = 5'd4;
      alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h0000CAFE; push(5'd4, 32'h0000CAFE);
      @(negedge clk);
      chk("x4_stall_gnt", {31'd0, issue_stall}, 32'd1);
      cyc();
      alu_valid = 0;
      @(negedge clk);
      chk("x4_byp2", {31'd0, byp2_valid}, BYP ? 32'd1 : 32'd0);
      chk("x4_byp1", {31'd0, byp1_valid}, 32'd0);
      chk("x4_bdata", byp_data, BYP ? 32'h0000CAFE : 32'd0);
      chk("x4_stall_we", {31'd0, issue_stall}, BYP ? 32'd0 : 32'd1);

      // Reset with a pending register and a write in flight
      cyc();
      issue_has_rd = 1; issue_rd = 5'd12; rs2_addr = 0;
      @(negedge clk);
      chk("x12_issue", {31'd0, issue_stall}, 32'd0);
      cyc();
      issue_valid = 0; issue_has_rd = 0;
      alu_valid = 1; alu_rd = 5'd13; alu_data = 32'h00001313;
      @(negedge clk);
      chk("x13_gnt", {31'd0, alu_ready}, 32'd1);
      cyc();
      alu_valid = 0;
      rst_n = 1'b0;
      issue_valid = 1; rs1_addr = 5'd12;
      @(negedge clk);
      chk("mid_rst_we", {31'd0, rf_we}, 32'd0);
      chk("mid_rst_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("mid_rst_pend", {31'd0, issue_stall}, 32'd0);
      cyc();
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_we", {31'd0, rf_we}, 32'd0);
      chk("post_rst_pend", {31'd0, issue_stall}, 32'd0);
      cyc();
      issue_valid = 0; rs1_addr = 0;
      repeat (3) cyc();
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Sequences the single write port of the 32x32 RISC-V register bank (x0 hardwired to zero, two combinational read ports).
- Arbitrates write-back between the ALU and the load/store unit (LSU), one write per cycle.
- Keeps a pending-write scoreboard per architectural register and raises a decode stall on RAW/WAW hazards.
- Sits between issue/decode, the execution units and the register bank write port.

Parameters:
- XLEN, 32, data width of one register.
- NREG, 32, number of architectural registers.
- AW, 5, register address width (log2 NREG).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode wants to issue an instruction.
- issue_has_rd  in  1  the issuing instruction writes rd.
- issue_rd  in  AW  destination register of the issuing instruction.
- rs1_addr  in  AW  source 1 of the issuing instruction.
- rs2_addr  in  AW  source 2 of the issuing instruction.
- issue_stall  out  1  combinational; 1 = hazard, instruction must not issue.
- alu_valid  in  1  ALU write-back request.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  combinational grant to the ALU.
- lsu_valid  in  1  LSU write-back request.
- lsu_rd  in  AW  LSU destination register.
- lsu_data  in  XLEN  load data.
- lsu_ready  out  1  combinational grant to the LSU.
- rf_we  out  1  registered write enable to the register bank.
- rf_waddr  out  AW  registered write address.
- rf_wdata  out  XLEN  registered write data.
- byp1_valid  out  1  forwarding hit on rs1 (optional feature; 0 when the feature is off).
- byp2_valid  out  1  forwarding hit on rs2 (optional feature; 0 when the feature is off).
- byp_data  out  XLEN  forwarded value, equal to rf_wdata (0 when the feature is off).

Behaviour:
- Reset (async, rst_n=0):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - Scoreboard pend[NREG-1:0]=0.
  - Priority pointer prio=0 (ALU favoured).
  - Combinational outputs follow from this state.
- Arbitration: round-robin over two requesters.
  - Only one valid: that requester is granted.
  - Both valid: the prio holder is granted, then prio flips to the other requester.
  - Single-requester grants leave prio unchanged.
  - A handshake is valid&&ready; a requester must hold rd/data stable until it is granted.
  - No backpressure from the register bank, so exactly one grant per cycle whenever any request is present.
- Write stage (registered, 1-cycle latency):
  - On a grant in cycle N, cycle N+1 has rf_we=1, rf_waddr=rd, rf_wdata=data.
  - The register bank stores the value at the end of N+1.
  - Granted rd=0: handshake completes, but rf_we stays 0 in N+1 and rf_waddr/rf_wdata hold their previous values.
- Scoreboard:
  - Set: issue_valid && issue_has_rd && !issue_stall && issue_rd!=0 sets pend[issue_rd].
  - Clear: in any cycle with rf_we=1, pend[rf_waddr] clears at the end of that cycle.
  - pend[0] is never set.
  - Set and clear cannot target the same register in one cycle, because the WAW stall blocks the set.
- issue_stall = issue_valid && (hz1 || hz2 || hzd), where:
  - hz1 = rs1_addr!=0 && pend[rs1_addr]
  - hz2 = rs2_addr!=0 && pend[rs2_addr]
  - hzd = issue_has_rd && issue_rd!=0 && pend[issue_rd]
- Feature off: a register stays hazardous through the rf_we cycle and is readable from the bank the next cycle.
- Reset mid-operation: all pending bits and any in-flight write are dropped, and no write reaches the bank.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - In a cycle with rf_we=1, rs1_addr==rf_waddr (nonzero) asserts byp1_valid; rs2_addr==rf_waddr asserts byp2_valid.
  - byp_data=rf_wdata.
  - hz1/hz2 are masked for that register, so RAW stalls shrink by one cycle.
  - hzd is not masked.
- Undefined: byp1_valid=byp2_valid=0, byp_data=0, and stall is as above.

Decomposition:
- Shared package rv_regfile_pkg holds:
  - Constants XLEN=32, NREG=32, AW=5, REG_ZERO=5'd0.
  - Typedef reg_addr_t (AW bits).
  - Typedef wb_req_t {valid, rd, data}.
- One sub-module, wb_rr_arbiter: 2-way round-robin with the prio flop; outputs the grant vector and the selected rd/data.
- Scoreboard and write register stay in the top module.

Test Plan:
- Reset, then alu_valid with rd=1, data=32'hDEADBEEF for 1 cycle -> alu_ready=1 that cycle; next cycle rf_we=1, rf_waddr=1, rf_wdata=DEADBEEF; register bank x1 reads DEADBEEF one cycle later.
- ALU (rd=2, BADC0DE0) and LSU (rd=3, 12345678) valid together for 2 cycles -> cycle 0 grants ALU, cycle 1 grants LSU; writes to x2 then x3 on consecutive cycles; prio ends on ALU.
- Issue rd=5, then issue rs1=5 -> issue_stall=1 until the rf_we cycle for x5 (feature off: also that cycle); deasserts the cycle after.
- Issue with rs1=0, rs2=0 while pend nonzero elsewhere -> issue_stall=0; LSU write to rd=0 -> lsu_ready=1, rf_we stays 0, pend unchanged.
- Issue rd=7 twice in consecutive cycles -> second issue stalls (WAW) until x7 write-back.
- With REGFILE_BYPASS_EN: rf_we to x4 with data 32'h0000CAFE while rs2_addr=4 -> byp2_valid=1, byp_data=0000CAFE, issue_stall=0; then assert rst_n=0 mid-stream -> rf_we=0 and pend=0 immediately.
